// File: rtl/shift_seq8_if.sv
// shift_seq8_if: operation request and result bus for shift_seq8; co exists only with SHIFT_SEQ8_CARRY_EN
interface shift_seq8_if;
  logic start;
  logic [1:0] op;
  logic [2:0] amt;
  logic [7:0] d_in;
  logic [7:0] q;
  logic busy;
  logic done;
`ifdef SHIFT_SEQ8_CARRY_EN
  logic co;
  modport master(output start, op, amt, d_in, input q, busy, done, co);
  modport slave(input start, op, amt, d_in, output q, busy, done, co);
`else
  modport master(output start, op, amt, d_in, input q, busy, done);
  modport slave(input start, op, amt, d_in, output q, busy, done);
`endif
endinterface

// File: rtl/shift_seq8.sv
// shift_seq8: sequential 8-bit shifter (LSL/LSR/ASR/ROR), one position per clock
// define SHIFT_SEQ8_CARRY_EN to add the co carry-out register and port
module shift_seq8 (
  input logic clk,
  input logic reset_n,
  shift_seq8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [7:0] q, q_n, sh;
  logic [1:0] op, op_n;
  logic [2:0] cnt, cnt_n;
  always_comb begin
    sh = op == 2'd0 ? {q[6:0], 1'b0} : op == 2'd1 ? {1'b0, q[7:1]} :
         op == 2'd2 ? {q[7], q[7:1]} : {q[0], q[7:1]};
    state_n = state;
    q_n = q;
    op_n = op;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.start) begin
        q_n = bus.d_in;
        op_n = bus.op;
        cnt_n = bus.amt;
        state_n = bus.amt != 3'd0 ? SHIFT : DONE;
      end
      SHIFT: begin
        q_n = sh;
        cnt_n = cnt - 3'd1;
        state_n = cnt == 3'd1 ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      q <= 8'h00;
      op <= 2'd0;
      cnt <= 3'd0;
    end else begin
      state <= state_n;
      q <= q_n;
      op <= op_n;
      cnt <= cnt_n;
    end
  end
`ifdef SHIFT_SEQ8_CARRY_EN
  logic co, co_n;
  always_comb co_n = state == IDLE && bus.start ? 1'b0 : state == SHIFT ? (op == 2'd0 ? q[7] : q[0]) : co;
  always_ff @(posedge clk) co <= !reset_n ? 1'b0 : co_n;
  assign bus.co = co;
`endif
  assign bus.q = q;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: randomized scoreboard bench for shift_seq8 with a behavioural shift model
module tb_shift_seq8;
  logic clk = 0;
  logic reset_n = 0;
  always #5 clk = ~clk;
  shift_seq8_if bus();
  shift_seq8 dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  typedef struct {logic [7:0] q; logic co; int amt; int edge_n;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, edge_cnt = 0, free_at = 0, run = 0;
  logic rst_at_edge = 0;
  logic [7:0] idle_q = 8'h00;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_at_edge <= reset_n;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask
  // {co, q} after shifting d by a positions, straight from the shift definitions
  function automatic logic [8:0] model(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d);
    int k;
    logic signed [7:0] s;
    logic [7:0] r;
    logic c;
    k = a;
    s = d;
    c = 1'b0;
    case (o)
      2'd0: begin r = d << k; if (k > 0) c = d[8 - k]; end
      2'd1: begin r = d >> k; if (k > 0) c = d[k - 1]; end
      2'd2: begin r = s >>> k; if (k > 0) c = d[k - 1]; end
      default: begin r = (d >> k) | (d << (8 - k)); if (k > 0) c = d[k - 1]; end
    endcase
    return {c, r};
  endfunction
  task automatic step(input logic rst, input logic st, input logic [1:0] o, input logic [2:0] a,
                      input logic [7:0] d, input logic dir, input logic [7:0] dq, input logic dco);
    int e;
    logic [8:0] m;
    exp_t x;
    @(posedge clk);
    #2;
    reset_n = !rst;
    bus.start = st;
    bus.op = o;
    bus.amt = a;
    bus.d_in = d;
    e = edge_cnt + 1;
    if (rst) begin
      free_at = e + 1;
      if (sb.size() > 0 && sb[$].edge_n >= e) void'(sb.pop_back());
    end else if (st && e >= free_at) begin
      m = model(o, a, d);
      x.q = dir ? dq : m[7:0];
      x.co = dir ? dco : m[8];
      x.amt = a;
      x.edge_n = e + a;
      sb.push_back(x);
      free_at = e + a + 2;
    end
  endtask
  task automatic idle();
    step(0, 0, 2'($urandom), 3'($urandom), 8'($urandom), 0, 0, 0);
  endtask
  task automatic go(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d,
                    input logic dir, input logic [7:0] dq, input logic dco);
    while (edge_cnt + 1 < free_at) idle();
    step(0, 1, o, a, d, dir, dq, dco);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) begin
      chk("reset_q", bus.q, 8'h00);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      idle_q = 8'h00;
      run = 0;
    end else begin
      run = bus.busy ? run + 1 : 0;
      if (!bus.busy) chk("idle_q_stable", bus.q, idle_q);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 q=%0h with no operation outstanding", bus.q);
        end else begin
          e = sb.pop_front();
          chk("done_q", bus.q, e.q);
          chk("done_latency", edge_cnt, e.edge_n);
          chk("busy_cycles", run, e.amt + 1);
`ifdef SHIFT_SEQ8_CARRY_EN
          chk("done_co", bus.co, e.co);
`endif
        end
        idle_q = bus.q;
      end
    end
  end
  initial begin
    bus.start = 0;
    bus.op = 0;
    bus.amt = 0;
    bus.d_in = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
    go(2'd0, 3'd3, 8'hB4, 1, 8'hA0, 1);
    go(2'd2, 3'd3, 8'hB4, 1, 8'hF6, 1);
    go(2'd1, 3'd2, 8'hB4, 1, 8'h2D, 0);
    go(2'd3, 3'd4, 8'hB4, 1, 8'h4B, 0);
    go(2'd0, 3'd0, 8'h3C, 1, 8'h3C, 0);
    repeat (14) step(0, 1, 2'($urandom), 3'd2, 8'($urandom), 0, 0, 0);
    repeat (400) step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                      2'($urandom), 3'($urandom), 8'($urandom), 0, 0, 0);
    go(2'd0, 3'd7, 8'h81, 0, 0, 0);
    repeat (3) idle();
    step(1, 1, 2'd0, 3'd1, 8'hFF, 0, 0, 0);
    go(2'd0, 3'd1, 8'h55, 1, 8'hAA, 0);
    repeat (12) idle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
